// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared VGA raster constants: default counter width, standard
//                800x600@60 and 640x480@60 timings (porches, sync, polarity),
//                derived line/frame totals and sync window bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default coordinate width; holds 1055 and 627 with room to spare.
    localparam int c_CNT_W = 11;

    // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs.
    localparam int c_SVGA_H_ACTIVE = 800;
    localparam int c_SVGA_H_FP     = 40;
    localparam int c_SVGA_H_SYNC   = 128;
    localparam int c_SVGA_H_BP     = 88;
    localparam int c_SVGA_V_ACTIVE = 600;
    localparam int c_SVGA_V_FP     = 1;
    localparam int c_SVGA_V_SYNC   = 4;
    localparam int c_SVGA_V_BP     = 23;
    localparam bit c_SVGA_H_POL    = 1'b1;
    localparam bit c_SVGA_V_POL    = 1'b1;

    localparam int c_SVGA_H_TOTAL  = c_SVGA_H_ACTIVE + c_SVGA_H_FP + c_SVGA_H_SYNC + c_SVGA_H_BP;
    localparam int c_SVGA_V_TOTAL  = c_SVGA_V_ACTIVE + c_SVGA_V_FP + c_SVGA_V_SYNC + c_SVGA_V_BP;
    localparam int c_SVGA_HS_START = c_SVGA_H_ACTIVE + c_SVGA_H_FP;
    localparam int c_SVGA_HS_END   = c_SVGA_HS_START + c_SVGA_H_SYNC;
    localparam int c_SVGA_VS_START = c_SVGA_V_ACTIVE + c_SVGA_V_FP;
    localparam int c_SVGA_VS_END   = c_SVGA_VS_START + c_SVGA_V_SYNC;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
    localparam int c_VGA_H_ACTIVE  = 640;
    localparam int c_VGA_H_FP      = 16;
    localparam int c_VGA_H_SYNC    = 96;
    localparam int c_VGA_H_BP      = 48;
    localparam int c_VGA_V_ACTIVE  = 480;
    localparam int c_VGA_V_FP      = 10;
    localparam int c_VGA_V_SYNC    = 2;
    localparam int c_VGA_V_BP      = 33;
    localparam bit c_VGA_H_POL     = 1'b0;
    localparam bit c_VGA_V_POL     = 1'b0;

    localparam int c_VGA_H_TOTAL   = c_VGA_H_ACTIVE + c_VGA_H_FP + c_VGA_H_SYNC + c_VGA_H_BP;
    localparam int c_VGA_V_TOTAL   = c_VGA_V_ACTIVE + c_VGA_V_FP + c_VGA_V_SYNC + c_VGA_V_BP;
    localparam int c_VGA_HS_START  = c_VGA_H_ACTIVE + c_VGA_H_FP;
    localparam int c_VGA_HS_END    = c_VGA_HS_START + c_VGA_H_SYNC;
    localparam int c_VGA_VS_START  = c_VGA_V_ACTIVE + c_VGA_V_FP;
    localparam int c_VGA_VS_END    = c_VGA_VS_START + c_VGA_V_SYNC;

    // Electrical sync level: the polarity when inside the window, else its inverse.
    function automatic logic sync_level(input logic i_asserted, input logic i_pol);
        return i_asserted ? i_pol : ~i_pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : Enable-gated shift register of DEPTH stages, WIDTH bits wide,
//                with a per-bit reset value. DEPTH=0 is a plain wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int              WIDTH   = 3,
    parameter int              DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_passthru
        logic w_unused;
        assign w_unused = ^{VGA_CLK, RST, i_en};
        assign o_q      = i_d;
    end else begin : g_stages
        logic [WIDTH-1:0] r_stages [DEPTH];

        // Shift one stage per enabled clock; async reset loads the idle pattern.
        always_ff @(posedge VGA_CLK or posedge RST) begin
            if (RST) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stages[i] <= RST_VAL;
                end
            end else if (i_en) begin
                r_stages[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stages[i] <= r_stages[i-1];
                end
            end
        end

        assign o_q = r_stages[DEPTH-1];
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. X/Y drive the frame
//                buffer fetch; HSYNC/VSYNC/DE are delayed PIPE enabled cycles
//                so they line up with fetched RGB at the connector.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_SVGA_H_ACTIVE,
    parameter int H_FP     = c_SVGA_H_FP,
    parameter int H_SYNC   = c_SVGA_H_SYNC,
    parameter int H_BP     = c_SVGA_H_BP,
    parameter int V_ACTIVE = c_SVGA_V_ACTIVE,
    parameter int V_FP     = c_SVGA_V_FP,
    parameter int V_SYNC   = c_SVGA_V_SYNC,
    parameter int V_BP     = c_SVGA_V_BP,
    parameter bit H_POL    = c_SVGA_H_POL,
    parameter bit V_POL    = c_SVGA_V_POL,
    parameter int CNT_W    = c_CNT_W,
    parameter int PIPE     = 2
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             EN,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             ACTIVE,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (CNT_W == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
        $error("vga_timing_gen: width parameters must be non-zero");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_err_pipe
        $error("vga_timing_gen: PIPE must be in 0..4");
    end
    if (CNT_W > 0 && CNT_W < 32 &&
        (c_H_TOTAL > (1 << CNT_W) || c_V_TOTAL > (1 << CNT_W))) begin : g_err_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    // Every bound below is strictly less than its total (porches are non-zero).
    localparam logic [CNT_W-1:0] c_H_MAX    = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_MAX    = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]       c_IDLE     = {~H_POL, ~V_POL, 1'b0};

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_active;
    logic [2:0]       w_raw;
    logic [2:0]       w_dly;

    // Raster counters: X runs every enabled cycle, Y steps on X wrap.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            r_x <= '0;
            r_y <= '0;
        end else if (EN) begin
            if (r_x == c_H_MAX) begin
                r_x <= '0;
                if (r_y == c_V_MAX) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + CNT_W'(1);
                end
            end else begin
                r_x <= r_x + CNT_W'(1);
            end
        end
    end

    // Fetch-stage decode straight from the counters.
    always_comb begin
        w_active = (r_x < c_H_ACT) && (r_y < c_V_ACT);
        w_hs_on  = (r_x >= c_HS_START) && (r_x < c_HS_END);
        w_vs_on  = (r_y >= c_VS_START) && (r_y < c_VS_END);
        w_raw    = {sync_level(w_hs_on, H_POL), sync_level(w_vs_on, V_POL), w_active};
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE),
        .RST_VAL (c_IDLE)
    ) u_dly (
        .VGA_CLK (VGA_CLK),
        .RST     (RST),
        .i_en    (EN),
        .i_d     (w_raw),
        .o_q     (w_dly)
    );

    assign X           = r_x;
    assign Y           = r_y;
    assign ACTIVE      = w_active;
    assign LINE_START  = (r_x == '0) && EN;
    assign FRAME_START = (r_x == '0) && (r_y == '0) && EN;
    assign HSYNC       = w_dly[2];
    assign VSYNC       = w_dly[1];
    assign DE          = w_dly[0];

endmodule

`default_nettype wire
